// File: rtl/regfile_scoreboard.sv
// Destination-register one-hot decoder and saturating pending-write scoreboard.
// Define SB_ZERO_REG_EN to treat register 0 as the hardwired $zero register (never tracked).
module regfile_scoreboard #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic                     iss_ready,
   output logic [(2**ADDR_W)-1:0]   iss_onehot,
   input  logic                     wb_valid,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic [ADDR_W-1:0]        rs_addr,
   input  logic [ADDR_W-1:0]        rt_addr,
   output logic                     rs_busy,
   output logic                     rt_busy,
   output logic [(2**ADDR_W)-1:0]   busy_vec,
   output logic                     err
);
   localparam int NREG = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef SB_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic [CNT_W-1:0] count_q [NREG];
   logic [CNT_W-1:0] count_d [NREG];
   logic             err_q;
   logic             err_set;
   logic             iss_fire;
   logic [NREG-1:0]  wb_onehot;
   logic [NREG-1:0]  fire_onehot;

   always_comb begin
      iss_onehot = '0;
      wb_onehot  = '0;
      busy_vec   = '0;
      for (int i = 0; i < NREG; i++) begin
         iss_onehot[i] = iss_valid && (iss_addr == ADDR_W'(i));
         wb_onehot[i]  = wb_valid && (wb_addr == ADDR_W'(i));
         busy_vec[i]   = (count_q[i] != '0) && !(ZERO_REG && i == 0);
      end
   end

   // A writeback to the same register frees a slot in the same cycle, so a full counter may still accept.
   always_comb begin
      iss_ready = !((count_q[iss_addr] == CNT_MAX) && !(wb_valid && (wb_addr == iss_addr)));
      if (ZERO_REG && (iss_addr == '0)) iss_ready = 1'b1;
   end

   assign iss_fire    = iss_valid && iss_ready;
   assign fire_onehot = iss_fire ? iss_onehot : '0;

   always_comb begin
      err_set = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         count_d[i] = count_q[i];
         if (fire_onehot[i] && !wb_onehot[i]) begin
            if (count_q[i] != CNT_MAX) count_d[i] = count_q[i] + CNT_W'(1);
         end else if (wb_onehot[i] && !fire_onehot[i]) begin
            if (count_q[i] != '0) count_d[i] = count_q[i] - CNT_W'(1);
         end
         if (wb_onehot[i] && (count_q[i] == '0) && !(ZERO_REG && i == 0)) err_set = 1'b1;
         if (ZERO_REG && i == 0) count_d[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) count_q[i] <= '0;
         err_q <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_q | err_set;
      end
   end

   assign rs_busy = busy_vec[rs_addr];
   assign rt_busy = busy_vec[rt_addr];
   assign err     = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: decode table, directed hazard sequences, randomized model check.
module tb_regfile_scoreboard;
   localparam int MAXC = 3;
`ifdef SB_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        iss_valid = 1'b0;
   logic [4:0]  iss_addr = '0;
   logic        iss_ready;
   logic [31:0] iss_onehot;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [4:0]  rs_addr = '0;
   logic [4:0]  rt_addr = '0;
   logic        rs_busy, rt_busy;
   logic [31:0] busy_vec;
   logic        err;

   regfile_scoreboard #(.ADDR_W(5), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready), .iss_onehot(iss_onehot),
      .wb_valid(wb_valid), .wb_addr(wb_addr),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .busy_vec(busy_vec), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cnt [32];
   bit err_m;

   typedef struct {
      logic        iv;
      logic [4:0]  ia;
      logic [31:0] exp_onehot;
      logic        exp_ready;
   } dec_vec_t;
   dec_vec_t dec_tab [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit m_ready(input int ia, input bit wv, input int wa);
      if (ZR && ia == 0) return 1'b1;
      return !(cnt[ia] == MAXC && !(wv && wa == ia));
   endfunction

   task automatic check_all();
      logic [31:0] eb = '0;
      logic [31:0] eo = '0;
      for (int r = 0; r < 32; r++) eb[r] = (cnt[r] > 0);
      if (iss_valid) eo[iss_addr] = 1'b1;
      chk("iss_ready", {31'b0, iss_ready}, {31'b0, m_ready(int'(iss_addr), wb_valid, int'(wb_addr))});
      chk("iss_onehot", iss_onehot, eo);
      chk("busy_vec", busy_vec, eb);
      chk("rs_busy", {31'b0, rs_busy}, {31'b0, eb[rs_addr]});
      chk("rt_busy", {31'b0, rt_busy}, {31'b0, eb[rt_addr]});
      chk("err", {31'b0, err}, {31'b0, err_m});
   endtask

   // Called at a negedge: drive, check the pre-edge view, cross the posedge, advance the model.
   task automatic cycle(input bit iv, input int ia, input bit wv, input int wa, input int ra, input int ta);
      bit fire;
      iss_valid = iv; iss_addr = 5'(ia); wb_valid = wv; wb_addr = 5'(wa);
      rs_addr = 5'(ra); rt_addr = 5'(ta);
      #1;
      check_all();
      fire = iv && m_ready(ia, wv, wa);
      @(posedge clk);
      for (int r = 0; r < 32; r++) begin
         int d;
         d = ((fire && ia == r) ? 1 : 0) - ((wv && wa == r) ? 1 : 0);
         if (wv && wa == r && cnt[r] == 0 && !(ZR && r == 0)) err_m = 1'b1;
         cnt[r] = cnt[r] + d;
         if (cnt[r] < 0) cnt[r] = 0;
         if (cnt[r] > MAXC) cnt[r] = MAXC;
         if (ZR && r == 0) cnt[r] = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      iss_valid = 1'b1; iss_addr = 5'($urandom_range(0, 31));
      wb_valid = 1'b1; wb_addr = 5'($urandom_range(0, 31));
      @(posedge clk);
      for (int r = 0; r < 32; r++) cnt[r] = 0;
      err_m = 1'b0;
      @(negedge clk);
      rst = 1'b0; iss_valid = 1'b0; wb_valid = 1'b0;
      #1;
   endtask

   task automatic idle(input int ra);
      cycle(0, 0, 0, 0, ra, 0);
   endtask

   initial begin
      dec_tab[0] = '{1'b1, 5'd31, 32'h8000_0000, 1'b1};
      dec_tab[1] = '{1'b1, 5'd0,  32'h0000_0001, 1'b1};
      dec_tab[2] = '{1'b0, 5'd7,  32'h0000_0000, 1'b1};
      dec_tab[3] = '{1'b1, 5'd8,  32'h0000_0100, 1'b1};
      dec_tab[4] = '{1'b0, 5'd31, 32'h0000_0000, 1'b1};

      @(negedge clk);
      do_reset();
      chk("rst_busy_vec", busy_vec, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      chk("rst_iss_ready", {31'b0, iss_ready}, 32'h1);

      // Decode table applied combinationally from the reset state, no clock edge in between.
      for (int k = 0; k < 5; k++) begin
         iss_valid = dec_tab[k].iv; iss_addr = dec_tab[k].ia; wb_valid = 1'b0;
         #1;
         chk($sformatf("dec_onehot[%0d]", k), iss_onehot, dec_tab[k].exp_onehot);
         chk($sformatf("dec_ready[%0d]", k), {31'b0, iss_ready}, {31'b0, dec_tab[k].exp_ready});
      end
      iss_valid = 1'b0;
      @(negedge clk);

      // Issue 8, busy one cycle later; writeback 8, clear one cycle later.
      cycle(1, 8, 0, 0, 8, 8);
      #1 chk("rs_busy_after_issue", {31'b0, rs_busy}, 32'h1);
      idle(8);
      cycle(0, 0, 1, 8, 8, 0);
      #1 chk("rs_busy_after_wb", {31'b0, rs_busy}, 32'h0);

      // Saturation of register 3.
      cycle(1, 3, 0, 0, 3, 0);
      cycle(1, 3, 0, 0, 3, 0);
      cycle(1, 3, 0, 0, 3, 0);
      iss_valid = 1'b1; iss_addr = 5'd3; wb_valid = 1'b0;
      #1 chk("sat_ready_low", {31'b0, iss_ready}, 32'h0);
      cycle(1, 3, 0, 0, 3, 0);
      iss_valid = 1'b1; iss_addr = 5'd3; wb_valid = 1'b1; wb_addr = 5'd3;
      #1 chk("sat_ready_with_wb", {31'b0, iss_ready}, 32'h1);
      cycle(1, 3, 1, 3, 3, 0);
      iss_valid = 1'b1; iss_addr = 5'd3; wb_valid = 1'b0;
      #1 chk("sat_count_held", {31'b0, iss_ready}, 32'h0);
      cycle(0, 0, 1, 3, 3, 0);
      cycle(0, 0, 1, 3, 3, 0);
      cycle(0, 0, 1, 3, 3, 0);
      #1 chk("sat_drained", {31'b0, busy_vec[3]}, 32'h0);

      // Independent issue to 4 and writeback to 9.
      cycle(1, 9, 0, 0, 9, 4);
      cycle(1, 4, 1, 9, 9, 4);
      #1 chk("indep_busy4", {31'b0, busy_vec[4]}, 32'h1);
      chk("indep_busy9", {31'b0, busy_vec[9]}, 32'h0);
      cycle(0, 0, 1, 4, 0, 0);

      // Spurious writeback to 12 sets a sticky err.
      cycle(0, 0, 1, 12, 12, 0);
      #1 chk("spur_err", {31'b0, err}, 32'h1);
      chk("spur_count0", {31'b0, busy_vec[12]}, 32'h0);
      for (int k = 0; k < 4; k++) idle(12);
      #1 chk("spur_err_sticky", {31'b0, err}, 32'h1);
      do_reset();
      chk("spur_err_cleared", {31'b0, err}, 32'h0);
      @(negedge clk);

      // Register 0 handling depends on the zero-register build.
      cycle(1, 0, 0, 0, 0, 0);
      #1 chk("zero_busy0", {31'b0, busy_vec[0]}, ZR ? 32'h0 : 32'h1);
      cycle(0, 0, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      #1 chk("zero_err", {31'b0, err}, ZR ? 32'h0 : 32'h1);

      // Randomized traffic over a few hot registers to exercise saturation and collisions.
      do_reset();
      @(negedge clk);
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
            @(negedge clk);
         end
         cycle($urandom_range(0, 1), $urandom_range(0, 4), ($urandom_range(0, 2) == 0),
               $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 31));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
